btpipe_out_buffer: RTL
======================

Name: btpipe_out_buffer

Overview:
- Transmit-side endpoint for the block-throttled pipe-out path, the counterpart of the block-throttled pipe-in receiver.
- User logic pushes 32-bit words into an internal FIFO. The block serves the okBTPipeOut read handshake and raises ep_ready only when a full block is available for the host.
- It sits between a data producer (pattern generator, capture logic) and the okBTPipeOut endpoint, all in the okClk domain.

Parameters:
- ADDR_W, 10: FIFO address width; depth DEPTH = 2**ADDR_W words.
- BLOCK_WORDS, 256: words per host block; must be a power of two with 1 <= BLOCK_WORDS <= DEPTH.
- FILL_WORD, 32'hDEADDEAD: word presented when the FIFO is read while empty.

Ports:
- clk  input  1  single clock, connected to okClk.
- reset_n  input  1  asynchronous active-low reset.
- wr_en  input  1  producer write strobe.
- wr_data  input  32  producer data.
- wr_full  output  1  FIFO full; writes accepted on this cycle are dropped unless a read occurs on the same cycle.
- ep_read  input  1  okBTPipeOut read strobe.
- ep_blockstrobe  input  1  okBTPipeOut block-start strobe, one cycle before the first ep_read of a block.
- ep_datain  output  32  data to okBTPipeOut.
- ep_ready  output  1  at least one uncommitted block is buffered.
- level  output  ADDR_W+1  words currently stored.
- overflow_count  output  16  dropped writes, saturating.
- underflow_count  output  16  reads while empty, saturating.
- protocol_err  output  1  sticky; set when the host starts a block while ep_ready is low.

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-low.
  - Reset values: ep_datain=0, ep_ready=0, wr_full=0, level=0, both counters=0, protocol_err=0.
  - Read/write pointers, level, avail and the tag counter also reset to 0.
  - Reset mid-block discards all buffered data and in-flight block state; there is no partial-block recovery.
- FIFO storage:
  - Circular buffer, pointers ADDR_W bits wide, wrapping naturally modulo DEPTH.
  - level = number of stored words, 0..DEPTH.
- Write:
  - If wr_en and (level<DEPTH or ep_read with level>0 on the same cycle): store the word and advance wr_ptr.
  - Otherwise a write with wr_en high is dropped and overflow_count increments, saturating at 16'hFFFF.
- Read:
  - If ep_read and level>0: ep_datain <= mem[rd_ptr] on the next rising edge (1-cycle latency, as okBTPipeOut requires), and rd_ptr advances.
  - If ep_read and level==0: ep_datain <= FILL_WORD, pointers hold, underflow_count increments (saturating).
  - When ep_read is low, ep_datain holds its value.
- Level arithmetic:
  - Write and read on the same cycle: level unchanged.
  - Write only: +1. Read only: -1.
  - wr_full = (level==DEPTH), registered together with level.
- Block accounting:
  - avail (ADDR_W+1 bits) counts stored words not yet committed to a host block.
  - Each accepted write: avail+1.
  - ep_blockstrobe: avail-BLOCK_WORDS.
  - If ep_blockstrobe and a write land on the same cycle, apply both changes.
  - If avail<BLOCK_WORDS at ep_blockstrobe: clamp avail to 0 and set protocol_err.
  - ep_ready is registered: ep_ready <= (next avail >= BLOCK_WORDS).
  - ep_ready falls the cycle after a blockstrobe that consumes the last full block.
  - Reads do not change avail; the words were already committed by the blockstrobe.
- Boundaries:
  - level==DEPTH with ep_ready=1 is legal.
  - BLOCK_WORDS==DEPTH requires a completely full FIFO before ep_ready asserts.

Optional Feature:
- Macro: BTPIPE_OUT_TAG_EN.
- Defined:
  - An 8-bit block sequence counter increments on each ep_blockstrobe and wraps 255->0.
  - The first word read after each blockstrobe has ep_datain[31:24] replaced with the pre-increment counter value; the first block is tagged 0.
  - All other words pass through unchanged.
- Not defined:
  - No counter exists, and data passes through untouched.

Decomposition:
- Package pipe_test_pkg holds:
  - BLOCK_WORDS default.
  - FILL_WORD.
  - the 32-bit word typedef.
  - the 16-bit saturating-counter typedef with its max constant.
- Sub-module pipe_fifo_ram: simple dual-port RAM of DEPTH x 32, one write port, one registered read port.
- Pointers, level/avail logic and the tag logic stay in the top module.

Test Plan:
- Reset, then write 255 words with BLOCK_WORDS=256 -> ep_ready stays 0. The 256th write -> ep_ready=1 one cycle later, level=256.
- One blockstrobe, then 256 reads of an incrementing pattern 0..255 -> ep_datain sequence 0..255, each word one cycle after its ep_read. Afterwards ep_ready=0 and level=0.
- Fill to DEPTH=1024, then 3 more writes -> overflow_count=3, wr_full=1. A write with simultaneous ep_read -> accepted, level stays 1024.
- ep_read on an empty FIFO twice -> ep_datain=32'hDEADDEAD, underflow_count=2. Blockstrobe with avail=10 -> protocol_err=1, avail=0.
- Assert reset_n low mid-block, after 100 of 256 reads -> all outputs return to reset values asynchronously. Refill -> the data stream restarts from the first new word.
- With BTPIPE_OUT_TAG_EN defined, run 3 blocks of all-ones data -> the first words read are 32'h00FFFFFF, 32'h01FFFFFF, 32'h02FFFFFF; all other words are 32'hFFFFFFFF.

Source files
------------

// File: rtl/pipe_test_pkg.sv
// Shared types and defaults for the block-throttled pipe-out buffer.
package pipe_test_pkg;

    typedef logic [31:0] word_t;
    typedef logic [15:0] sat16_t;

    localparam sat16_t SAT16_MAX        = 16'hFFFF;
    localparam int     PIPE_BLOCK_WORDS = 256;
    localparam word_t  PIPE_FILL_WORD   = 32'hDEADDEAD;

endpackage

// File: rtl/pipe_fifo_ram.sv
// Simple dual-port DEPTH x 32 RAM: one write port, one registered read port.
// A read and a write to the same address on one edge return the old word.
module pipe_fifo_ram
    import pipe_test_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  word_t             wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output word_t             rdata
);

    word_t mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rdata <= '0;
        else if (re)  rdata <= mem[raddr];
    end

endmodule

// File: rtl/btpipe_out_buffer.sv
// Block-throttled pipe-out transmit buffer: FIFO plus host block accounting.
// Optional block sequence tagging of the first word per block: BTPIPE_OUT_TAG_EN.
module btpipe_out_buffer
    import pipe_test_pkg::*;
#(
    parameter int    ADDR_W      = 10,
    parameter int    BLOCK_WORDS = PIPE_BLOCK_WORDS,
    parameter word_t FILL_WORD   = PIPE_FILL_WORD
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [31:0]       wr_data,
    output logic              wr_full,
    input  logic              ep_read,
    input  logic              ep_blockstrobe,
    output logic [31:0]       ep_datain,
    output logic              ep_ready,
    output logic [ADDR_W:0]   level,
    output logic [15:0]       overflow_count,
    output logic [15:0]       underflow_count,
    output logic              protocol_err
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(2**ADDR_W);
    localparam logic [ADDR_W:0] BLK_L   = (ADDR_W+1)'(BLOCK_WORDS);

    function automatic sat16_t sat_inc(input sat16_t v);
        return (v == SAT16_MAX) ? v : v + 16'd1;
    endfunction

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   avail;
    logic [ADDR_W:0]   level_nxt, avail_nxt;
    logic              rd_ok, wr_ok, blk_short;
    word_t             ram_q_p1;
    logic              rd_fill_p1;

    // A full FIFO still accepts a write when a read frees a slot on the same edge.
    always_comb begin
        rd_ok     = ep_read && (level != '0);
        wr_ok     = wr_en && ((level != DEPTH_L) || rd_ok);
        blk_short = ep_blockstrobe && (avail < BLK_L);
        level_nxt = level + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);
        avail_nxt = avail;
        if (ep_blockstrobe) avail_nxt = blk_short ? '0 : avail - BLK_L;
        avail_nxt = avail_nxt + (ADDR_W+1)'(wr_ok);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            level           <= '0;
            avail           <= '0;
            wr_full         <= 1'b0;
            ep_ready        <= 1'b0;
            overflow_count  <= '0;
            underflow_count <= '0;
            protocol_err    <= 1'b0;
            rd_fill_p1      <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_ok) rd_ptr <= rd_ptr + ADDR_W'(1);
            level    <= level_nxt;
            wr_full  <= (level_nxt == DEPTH_L);
            avail    <= avail_nxt;
            ep_ready <= (avail_nxt >= BLK_L);
            if (wr_en && !wr_ok)   overflow_count  <= sat_inc(overflow_count);
            if (ep_read && !rd_ok) underflow_count <= sat_inc(underflow_count);
            if (blk_short)         protocol_err    <= 1'b1;
            if (ep_read)           rd_fill_p1      <= !rd_ok;
        end
    end

    // ---- p0 -> p1: RAM read register, one cycle behind ep_read ----
    pipe_fifo_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (wr_ok),
        .waddr   (wr_ptr),
        .wdata   (wr_data),
        .re      (rd_ok),
        .raddr   (rd_ptr),
        .rdata   (ram_q_p1)
    );

`ifdef BTPIPE_OUT_TAG_EN
    logic [7:0] blk_seq, tag_val, tag_byte_p1;
    logic       tag_pend, tag_hit_p1;

    // The tag byte is latched at read time so a later strobe cannot alter a held word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk_seq     <= '0;
            tag_val     <= '0;
            tag_pend    <= 1'b0;
            tag_hit_p1  <= 1'b0;
            tag_byte_p1 <= '0;
        end else begin
            if (ep_blockstrobe) begin
                tag_val  <= blk_seq;
                blk_seq  <= blk_seq + 8'd1;
                tag_pend <= 1'b1;
            end else if (rd_ok) begin
                tag_pend <= 1'b0;
            end
            if (ep_read) begin
                tag_hit_p1  <= rd_ok && tag_pend;
                tag_byte_p1 <= tag_val;
            end
        end
    end
`endif

    always_comb begin
        ep_datain = rd_fill_p1 ? FILL_WORD : ram_q_p1;
`ifdef BTPIPE_OUT_TAG_EN
        if (tag_hit_p1) ep_datain[31:24] = tag_byte_p1;
`endif
    end

endmodule
